xc_aesmix_seq: RTL and testbench
================================

// Module: xc_aesmix_seq
// PURPOSE
//  Sequences a full 128-bit AES-state MixColumns (enc) or InvMixColumns (dec) through one shared
//  32-bit xc_aesmix instance, one column per operation. Works with FAST and 4-cycle builds of the
//  mix unit. Sits between the crypto issue logic (req/rsp valid-ready) and the mix unit port.
// PARAMETERS
//  MIX_TIMEOUT  16  max ISSUE cycles per column awaiting mix_ready; 0 = timeout disabled
// PORTS
//  clock           in   1    system clock, all state on rising edge
//  resetn          in   1    asynchronous, active-low reset
//  req_valid       in   1    request present
//  req_ready       out  1    request accepted when req_valid && req_ready
//  req_enc         in   1    1 = MixColumns, 0 = InvMixColumns
//  req_state       in   128  AES state; column c = req_state[32*c+:32], byte0 in bits [7:0]
//  rsp_valid       out  1    result present, held until rsp_ready
//  rsp_ready       in   1    consumer accepts result
//  rsp_state       out  128  mixed state, same column/byte packing as req_state
//  rsp_error       out  1    qualified by rsp_valid: column timed out
//  busy            out  1    state != IDLE
//  mix_valid       out  1    to mix unit valid
//  mix_enc         out  1    to mix unit enc
//  mix_rs1,mix_rs2 out  32   to mix unit rs1/rs2; both carry the current column word
//  mix_flush       out  1    to mix unit flush
//  mix_flush_data  out  32   to mix unit flush_data; constant 0
//  mix_ready       in   1    from mix unit ready
//  mix_result      in   32   from mix unit result
// BEHAVIOUR
//  States IDLE, FLUSH, ISSUE, RESP; 2-bit column counter col; timer of clog2(MIX_TIMEOUT+1) bits.
//  Reset (resetn low): state IDLE, col 0, timer 0, request/result regs 0; all outputs 0 incl.
//   req_ready (gated by a flag set on the first clock after resetn rises).
//  IDLE: req_ready=1. On accept: latch req_state, req_enc, col<=0 -> FLUSH.
//  FLUSH: mix_flush=1, mix_valid=0, exactly 1 cycle; timer<=0 -> ISSUE. Every column
//   (incl. col 0) is preceded by a flush, so mix-unit state left by reset/abort never leaks.
//  ISSUE: mix_valid=1, mix_rs1=mix_rs2=word[col], mix_enc=latched enc; held stable until mix_ready.
//   mix_ready: rsp_state[32*col+:32]<=mix_result; col==3 -> RESP, else col++ -> FLUSH.
//   no mix_ready: timer++; ISSUE cycle MIX_TIMEOUT without ready -> err<=1, rsp_state<=0 -> RESP.
//  RESP: rsp_valid=1, rsp_state/rsp_error stable until rsp_ready; rsp_ready -> IDLE (err cleared);
//   req_ready returns 1 the next cycle (no same-cycle rsp->req bypass).
//  mix_ready/mix_result ignored outside ISSUE. mix_* outputs 0 in IDLE and RESP.
//  Latency, accept edge = cycle 0: FAST unit rsp_valid at cycle 9; 4-cycle unit at cycle 21.
//  Reset mid-operation: immediate abandon, no rsp issued, no partial result visible.
// CONFIGURATION
//  XC_AESMIX_SEQ_ROUNDKEY_EN defined: adds input req_rkey[127:0], latched at accept; each
//   captured column = mix_result ^ rkey[32*col+:32] (fused AddRoundKey); timeout output stays 0.
//  Undefined: no req_rkey port; rsp_state = raw mix results.
// TESTING
//  1 enc, FAST model, all 4 columns 0x455313db -> each column 0xbca14d8e, rsp_valid at cycle 9.
//  2 dec, 4-cycle model, all columns 0xbca14d8e -> each column 0x455313db, rsp_valid at cycle 21;
//    mix_flush seen exactly 4 times, each 1 cycle, each before mix_valid of its column.
//  3 rsp_ready low 5 cycles after rsp_valid -> rsp_state/rsp_valid stable, req_ready 0; after
//    handshake busy=0 and req_ready=1 next cycle; back-to-back second request is correct.
//  4 MIX_TIMEOUT=16, mix_ready tied 0 -> 16 ISSUE cycles on col 0, then rsp_valid=1, rsp_error=1,
//    rsp_state=0; a following request with a working model gives rsp_error=0.
//  5 resetn low during ISSUE of col 2 -> all outputs 0 at once; after release, a new enc request
//    of test 1 gives the test 1 result and its first mix-port activity is a flush.
//  6 ROUNDKEY_EN, test 1 with req_rkey=all ones -> each column 0x435eb271.

Source files
------------

// File: rtl/xc_aesmix_seq.sv
// Sequences a 128-bit AES MixColumns/InvMixColumns through one shared 32-bit mix unit, one column per op.
// Optional build macro: XC_AESMIX_SEQ_ROUNDKEY_EN fuses AddRoundKey into each captured column.
module xc_aesmix_seq #(
  parameter int unsigned MIX_TIMEOUT = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_enc,
  input  logic [127:0] req_state,
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
  input  logic [127:0] req_rkey,
`endif
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         rsp_error,
  output logic         busy,
  output logic         mix_valid,
  output logic         mix_enc,
  output logic [31:0]  mix_rs1,
  output logic [31:0]  mix_rs2,
  output logic         mix_flush,
  output logic [31:0]  mix_flush_data,
  input  logic         mix_ready,
  input  logic [31:0]  mix_result
);

  localparam int unsigned TW    = (MIX_TIMEOUT == 0) ? 1 : $clog2(MIX_TIMEOUT + 1);
  localparam bit          TO_EN = (MIX_TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ISSUE, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   req_q, req_d;
  logic           enc_q, enc_d;
  logic           err_q, err_d;
  logic [127:0]   rsp_q, rsp_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           busy_q, busy_d;
  logic           mix_valid_q, mix_valid_d;
  logic           mix_enc_q, mix_enc_d;
  logic           mix_flush_q, mix_flush_d;
  logic [31:0]    mix_word_q, mix_word_d;
  logic [31:0]    capture;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
  logic [127:0]   rkey_q, rkey_d;
`endif

  // Column word as written back; round key is folded in when fused AddRoundKey is built
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
  assign capture = mix_result ^ rkey_q[{col_q, 5'd0} +: 32];
`else
  assign capture = mix_result;
`endif

  // Next-state and next-output logic; every output is the flopped image of the next state
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    timer_d = timer_q;
    req_d   = req_q;
    enc_d   = enc_q;
    err_d   = err_q;
    rsp_d   = rsp_q;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    rkey_d  = rkey_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d   = req_state;
          enc_d   = req_enc;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
          rkey_d  = req_rkey;
`endif
          col_d   = 2'd0;
          err_d   = 1'b0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        timer_d = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (mix_ready) begin
          rsp_d[{col_q, 5'd0} +: 32] = capture;
          if (col_q == 2'd3) begin
            state_d = S_RESP;
          end else begin
            col_d   = col_q + 2'd1;
            state_d = S_FLUSH;
          end
        end else if (TO_EN && (timer_q == TW'(MIX_TIMEOUT - 1))) begin
          err_d   = 1'b1;
          rsp_d   = '0;
          state_d = S_RESP;
        end else if (TO_EN) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    mix_flush_d = (state_d == S_FLUSH);
    mix_valid_d = (state_d == S_ISSUE);
    mix_enc_d   = (state_d == S_ISSUE) ? enc_d : 1'b0;
    mix_word_d  = (state_d == S_ISSUE) ? req_d[{col_d, 5'd0} +: 32] : 32'd0;
  end

  // State and output registers; req_ready rises on the first clock after reset release
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      col_q       <= 2'd0;
      timer_q     <= '0;
      req_q       <= '0;
      enc_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mix_valid_q <= 1'b0;
      mix_enc_q   <= 1'b0;
      mix_flush_q <= 1'b0;
      mix_word_q  <= 32'd0;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
      rkey_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      enc_q       <= enc_d;
      err_q       <= err_d;
      rsp_q       <= rsp_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      mix_valid_q <= mix_valid_d;
      mix_enc_q   <= mix_enc_d;
      mix_flush_q <= mix_flush_d;
      mix_word_q  <= mix_word_d;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
      rkey_q      <= rkey_d;
`endif
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_state      = rsp_q;
  assign rsp_error      = err_q;
  assign busy           = busy_q;
  assign mix_valid      = mix_valid_q;
  assign mix_enc        = mix_enc_q;
  assign mix_rs1        = mix_word_q;
  assign mix_rs2        = mix_word_q;
  assign mix_flush      = mix_flush_q;
  assign mix_flush_data = 32'd0;

endmodule

// File: tb/tb_xc_aesmix_seq.sv
// Bench for xc_aesmix_seq: behavioural mix unit (FAST / 4-cycle / dead) plus an expected-result scoreboard.
module tb_xc_aesmix_seq;

  logic         clock = 1'b0;
  logic         resetn;
  logic         req_valid, req_ready, req_enc;
  logic [127:0] req_state;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
  logic [127:0] req_rkey;
`endif
  logic         rsp_valid, rsp_ready, rsp_error, busy;
  logic [127:0] rsp_state;
  logic         mix_valid, mix_enc, mix_flush, mix_ready;
  logic [31:0]  mix_rs1, mix_rs2, mix_flush_data, mix_result;

  always #5 clock = ~clock;

  xc_aesmix_seq #(.MIX_TIMEOUT(16)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc), .req_state(req_state),
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    .req_rkey(req_rkey),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_error(rsp_error),
    .busy(busy), .mix_valid(mix_valid), .mix_enc(mix_enc), .mix_rs1(mix_rs1), .mix_rs2(mix_rs2),
    .mix_flush(mix_flush), .mix_flush_data(mix_flush_data), .mix_ready(mix_ready),
    .mix_result(mix_result)
  );

  // Mix unit model: mode 0 = FAST (ready with valid), 1 = ready on 4th valid cycle, 2 = never ready
  int         mode = 0;
  logic [1:0] cnt = 2'd0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mixcol(input logic enc, input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] r [4];
    logic [7:0] m [4];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (enc) begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    else     begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    for (int i = 0; i < 4; i++)
      r[i] = gmul(b[i], m[0]) ^ gmul(b[(i+1)%4], m[1]) ^ gmul(b[(i+2)%4], m[2]) ^ gmul(b[(i+3)%4], m[3]);
    return {r[3], r[2], r[1], r[0]};
  endfunction

  assign mix_ready  = (mode == 0) ? mix_valid : (mode == 1) ? (mix_valid && cnt == 2'd3) : 1'b0;
  assign mix_result = mix_valid ? mixcol(mix_enc, mix_rs1) : 32'hdeadbeef;

  always_ff @(posedge clock) begin
    if (mix_flush)                   cnt <= 2'd0;
    else if (mix_valid && !mix_ready) cnt <= cnt + 2'd1;
    else                             cnt <= 2'd0;
  end

  typedef struct packed { logic [127:0] st; logic err; } exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_rsp(input logic [127:0] st, input logic err);
    exp_t e;
    e.st = st; e.err = err;
    sb.push_back(e);
  endtask

  task automatic send(input logic [127:0] st, input logic enc, input logic [127:0] rkey);
    logic acc = 1'b0;
    req_state = st; req_enc = enc; req_valid = 1'b1;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    req_rkey = rkey;
`else
    if (rkey != '0) $display("note: round key ignored in this build");
`endif
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = req_ready;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    chk("accept", 128'(acc), 128'(1));
  endtask

  // Runs one request to completion from cycle 1 after accept; returns port activity counts
  task automatic collect(input int exp_lat, input int hold, output int nflush, output int nvalid,
                         output int bad);
    int cyc = 1;
    logic pf = 1'b0, pv = 1'b0, unstable = 1'b0;
    logic [127:0] snap;
    exp_t e;
    nflush = 0; nvalid = 0; bad = 0;
    while (!rsp_valid && cyc < 200) begin
      if (mix_flush) begin nflush++; if (pf || mix_valid) bad++; end
      if (mix_valid) begin nvalid++; if (!pv && !pf) bad++; end
      pf = mix_flush; pv = mix_valid;
      @(posedge clock); #1; cyc++;
    end
    chk("rsp_valid", 128'(rsp_valid), 128'(1));
    if (exp_lat != 0) chk("latency", 128'(cyc), 128'(exp_lat));
    chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_state", rsp_state, e.st);
      chk("rsp_error", 128'(rsp_error), 128'(e.err));
    end
    snap = rsp_state;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (rsp_state !== snap || !rsp_valid || req_ready || mix_valid || mix_flush) unstable = 1'b1;
    end
    if (hold > 0) chk("hold_stable", 128'(unstable), 128'(0));
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("post_busy", 128'(busy), 128'(0));
    chk("post_req_ready", 128'(req_ready), 128'(1));
    chk("post_rsp_valid", 128'(rsp_valid), 128'(0));
  endtask

  localparam logic [127:0] ENC_IN  = {4{32'h455313db}};
  localparam logic [127:0] ENC_OUT = {4{32'hbca14d8e}};
  localparam logic [127:0] MIX_IN  = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] MIX_OUT = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};

  int nf, nv, bd;

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_enc = 1'b0; req_state = '0; rsp_ready = 1'b0;
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    req_rkey = '0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 128'(|{req_ready, rsp_valid, rsp_state, rsp_error, busy, mix_valid, mix_enc,
                                mix_rs1, mix_rs2, mix_flush, mix_flush_data}), 128'(0));
    resetn = 1'b1;
    #1 chk("ready_gated", 128'(req_ready), 128'(0));
    @(posedge clock); #1;
    chk("ready_after_reset", 128'(req_ready), 128'(1));

    // 1: FAST enc
    mode = 0;
    expect_rsp(ENC_OUT, 1'b0);
    send(ENC_IN, 1'b1, '0);
    collect(9, 0, nf, nv, bd);
    chk("t1_flushes", 128'(nf), 128'(4));

    // 2: 4-cycle dec, flush ordering
    mode = 1;
    expect_rsp(ENC_IN, 1'b0);
    send(ENC_OUT, 1'b0, '0);
    collect(21, 0, nf, nv, bd);
    chk("t2_flushes", 128'(nf), 128'(4));
    chk("t2_flush_order", 128'(bd), 128'(0));
    chk("t2_issue_cycles", 128'(nv), 128'(16));

    // 3: back-pressure then back-to-back inverse request
    mode = 0;
    expect_rsp(MIX_OUT, 1'b0);
    send(MIX_IN, 1'b1, '0);
    collect(9, 5, nf, nv, bd);
    expect_rsp(MIX_IN, 1'b0);
    send(MIX_OUT, 1'b0, '0);
    collect(9, 0, nf, nv, bd);

    // 4: timeout on column 0, then recovery
    mode = 2;
    expect_rsp('0, 1'b1);
    send(MIX_IN, 1'b1, '0);
    collect(18, 0, nf, nv, bd);
    chk("t4_issue_cycles", 128'(nv), 128'(16));
    mode = 0;
    expect_rsp(ENC_OUT, 1'b0);
    send(ENC_IN, 1'b1, '0);
    collect(9, 0, nf, nv, bd);

    // 5: reset during column 2 issue
    expect_rsp(ENC_OUT, 1'b0);
    send(ENC_IN, 1'b1, '0);
    repeat (5) begin @(posedge clock); #1; end
    chk("t5_in_issue", 128'(mix_valid), 128'(1));
    resetn = 1'b0;
    #1;
    chk("t5_reset_outputs", 128'(|{req_ready, rsp_valid, rsp_state, rsp_error, busy, mix_valid, mix_enc,
                                   mix_rs1, mix_rs2, mix_flush, mix_flush_data}), 128'(0));
    if (sb.size() != 0) void'(sb.pop_front());
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("t5_ready", 128'(req_ready), 128'(1));
    expect_rsp(ENC_OUT, 1'b0);
    send(ENC_IN, 1'b1, '0);
    chk("t5_first_is_flush", 128'({mix_flush, mix_valid}), 128'(2'b10));
    collect(9, 0, nf, nv, bd);
    chk("t5_flush_order", 128'(bd), 128'(0));

`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    // 6: fused AddRoundKey
    expect_rsp({4{32'h435eb271}}, 1'b0);
    send(ENC_IN, 1'b1, {128{1'b1}});
    collect(9, 0, nf, nv, bd);
`endif

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
